// File: rtl/uart_cmd_decoder.sv
// UART register-access command decoder: count/address registers, read-back over tx,
// and single memory write/read requests with an ACK byte on completion.
//
// state | meaning
// IDLE  | waiting for a command byte
// ARG   | write command latched, waiting for its argument byte (timed)
// RESP  | byte presented on tx, waiting for tx_ready
// MEM   | memory request outstanding, waiting for mem_ack
module uart_cmd_decoder #(
   parameter int          TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  ACK_BYTE       = 8'hAA
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic [7:0]  mem_count,
   output logic [31:0] mem_addr,
   output logic        mem_req,
   output logic        mem_we,
   input  logic        mem_ack,
   output logic        busy,
   output logic        err
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TMR_LOAD = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] TMR_ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, ARG, RESP, MEM} state_t;

   state_t        state, state_nxt;
   logic [2:0]    tgt, tgt_nxt;
   logic [CW-1:0] tmr, tmr_nxt;
   logic [7:0]    tx_data_nxt, mem_count_nxt;
   logic [31:0]   mem_addr_nxt;
   logic          mem_we_nxt, err_nxt;

   assign tx_valid = (state == RESP);
   assign mem_req  = (state == MEM);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tgt       <= 3'd0;
         tmr       <= '0;
         tx_data   <= 8'h00;
         mem_count <= 8'h00;
         mem_addr  <= 32'h0;
         mem_we    <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         tgt       <= tgt_nxt;
         tmr       <= tmr_nxt;
         tx_data   <= tx_data_nxt;
         mem_count <= mem_count_nxt;
         mem_addr  <= mem_addr_nxt;
         mem_we    <= mem_we_nxt;
         err       <= err_nxt;
      end
   end

   // tgt: 0 = count, 1..4 = address byte 0..3
   always_comb begin
      state_nxt     = state;
      tgt_nxt       = tgt;
      tmr_nxt       = tmr;
      tx_data_nxt   = tx_data;
      mem_count_nxt = mem_count;
      mem_addr_nxt  = mem_addr;
      mem_we_nxt    = mem_we;
      err_nxt       = 1'b0;
      case (state)
         IDLE: begin
            if (rx_valid) begin
               case (rx_data)
                  8'h61, 8'h63, 8'h64, 8'h65, 8'h66: begin
                     tgt_nxt   = (rx_data == 8'h61) ? 3'd0 : rx_data[2:0] - 3'd2;
                     tmr_nxt   = TMR_LOAD;
                     state_nxt = ARG;
                  end
                  8'h62: begin tx_data_nxt = mem_count;       state_nxt = RESP; end
                  8'h67: begin tx_data_nxt = mem_addr[7:0];   state_nxt = RESP; end
                  8'h68: begin tx_data_nxt = mem_addr[15:8];  state_nxt = RESP; end
                  8'h69: begin tx_data_nxt = mem_addr[23:16]; state_nxt = RESP; end
                  8'h6A: begin tx_data_nxt = mem_addr[31:24]; state_nxt = RESP; end
                  8'hD0: begin mem_we_nxt = 1'b1; state_nxt = MEM; end
                  8'hD1: begin mem_we_nxt = 1'b0; state_nxt = MEM; end
                  default: err_nxt = 1'b1;
               endcase
            end
         end
         ARG: begin
            // an argument arriving on the timeout cycle still wins
            if (rx_valid) begin
               case (tgt)
                  3'd0:    mem_count_nxt          = rx_data;
                  3'd1:    mem_addr_nxt[7:0]      = rx_data;
                  3'd2:    mem_addr_nxt[15:8]     = rx_data;
                  3'd3:    mem_addr_nxt[23:16]    = rx_data;
                  3'd4:    mem_addr_nxt[31:24]    = rx_data;
                  default: mem_count_nxt          = mem_count;
               endcase
               state_nxt = IDLE;
            end else if (tmr == '0) begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               tmr_nxt = tmr - TMR_ONE;
            end
         end
         RESP: begin
            err_nxt = rx_valid;
            if (tx_ready) state_nxt = IDLE;
         end
         MEM: begin
            err_nxt = rx_valid;
            if (mem_ack) begin
               tx_data_nxt = ACK_BYTE;
               state_nxt   = RESP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed and randomized bench for uart_cmd_decoder against a byte-level model
// of the count/address registers and the expected tx responses.
module tb_uart_cmd_decoder;
   localparam int TO = 40;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid, tx_ready, mem_ack;
   logic [7:0]  rx_data;
   logic        tx_valid, mem_req, mem_we, busy, err;
   logic [7:0]  tx_data, mem_count;
   logic [31:0] mem_addr;

   int total = 0;
   int bad   = 0;

   logic [7:0] m_count;
   logic [7:0] m_addr [4];

   always #5 clk = ~clk;

   uart_cmd_decoder #(.TIMEOUT_CYCLES(TO), .ACK_BYTE(8'hAA)) dut (
      .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
      .mem_count(mem_count), .mem_addr(mem_addr), .mem_req(mem_req),
      .mem_we(mem_we), .mem_ack(mem_ack), .busy(busy), .err(err)
   );

   function automatic logic [31:0] m_word();
      return {m_addr[3], m_addr[2], m_addr[1], m_addr[0]};
   endfunction

   function automatic bit is_cmd(input logic [7:0] b);
      return (b >= 8'h61 && b <= 8'h6A) || b == 8'hD0 || b == 8'hD1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_regs(input string tag);
      chk({tag, "_count"}, {24'h0, mem_count}, {24'h0, m_count});
      chk({tag, "_addr"}, mem_addr, m_word());
   endtask

   // called just after a negedge; byte is sampled on the next posedge
   task automatic send_byte(input logic [7:0] b, output logic e);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      e        = err;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic accept(input string tag);
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      chk({tag, "_txv_off"}, {31'h0, tx_valid}, 32'h0);
      chk({tag, "_idle"}, {31'h0, busy}, 32'h0);
   endtask

   task automatic do_write(input int idx, input logic [7:0] val, input int gap);
      logic e;
      send_byte((idx == 0) ? 8'h61 : 8'(8'h62 + idx), e);
      chk("wr_cmd_err", {31'h0, e}, 32'h0);
      chk("wr_arg_busy", {31'h0, busy}, 32'h1);
      repeat (gap) @(negedge clk);
      send_byte(val, e);
      chk("wr_arg_err", {31'h0, e}, 32'h0);
      if (idx == 0) m_count = val;
      else          m_addr[idx-1] = val;
      chk_regs("wr");
      chk("wr_done_idle", {31'h0, busy}, 32'h0);
   endtask

   task automatic do_read(input int idx, input int hold);
      logic e;
      logic [7:0] exp;
      exp = (idx == 0) ? m_count : m_addr[idx-1];
      send_byte((idx == 0) ? 8'h62 : 8'(8'h66 + idx), e);
      chk("rd_err", {31'h0, e}, 32'h0);
      chk("rd_txv", {31'h0, tx_valid}, 32'h1);
      chk("rd_data", {24'h0, tx_data}, {24'h0, exp});
      repeat (hold) @(negedge clk);
      chk("rd_data_hold", {24'h0, tx_data}, {24'h0, exp});
      accept("rd");
      chk_regs("rd");
   endtask

   task automatic do_mem(input logic we, input int lat);
      logic e;
      send_byte(we ? 8'hD0 : 8'hD1, e);
      chk("mem_err", {31'h0, e}, 32'h0);
      chk("mem_req", {31'h0, mem_req}, 32'h1);
      chk("mem_we", {31'h0, mem_we}, {31'h0, we});
      repeat (lat) @(negedge clk);
      chk("mem_req_held", {30'h0, mem_req, mem_we}, {30'h0, 1'b1, we});
      chk("mem_no_tx", {31'h0, tx_valid}, 32'h0);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("mem_req_drop", {31'h0, mem_req}, 32'h0);
      chk("mem_ack_txv", {31'h0, tx_valid}, 32'h1);
      chk("mem_ack_byte", {24'h0, tx_data}, 32'hAA);
      accept("mem");
   endtask

   task automatic do_bad();
      logic e;
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      while (is_cmd(b)) b = 8'($urandom_range(0, 255));
      send_byte(b, e);
      chk("bad_err", {31'h0, e}, 32'h1);
      chk("bad_idle", {30'h0, busy, tx_valid}, 32'h0);
      chk_regs("bad");
      @(negedge clk);
      chk("bad_err_1cyc", {31'h0, err}, 32'h0);
   endtask

   initial begin
      logic e;
      logic [7:0] v;
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; mem_ack = 1'b0;
      m_count = 8'h00;
      for (int i = 0; i < 4; i++) m_addr[i] = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_outs", {26'h0, tx_valid, mem_req, mem_we, busy, err, 1'b0}, 32'h0);
      chk("rst_txd", {24'h0, tx_data}, 32'h0);
      chk_regs("rst");

      do_read(0, 0);
      do_write(0, 8'h34, 0);
      do_read(0, 1);
      do_write(1, 8'hAB, 0); do_write(2, 8'hCD, 2);
      do_write(3, 8'hEF, 0); do_write(4, 8'hCD, 1);
      chk("addr_word", mem_addr, 32'hCDEFCDAB);
      for (int i = 1; i <= 4; i++) do_read(i, 0);
      do_mem(1'b1, 5);
      do_mem(1'b0, 5);
      do_bad();

      // mem_ack outside MEM is ignored
      mem_ack = 1'b1; @(negedge clk); mem_ack = 1'b0;
      chk("stray_ack", {29'h0, busy, tx_valid, mem_req}, 32'h0);

      // timeout: no argument -> err exactly on the TO-th idle ARG cycle
      send_byte(8'h61, e);
      repeat (TO - 1) @(negedge clk);
      chk("to_still_arg", {30'h0, busy, err}, 32'h2);
      @(negedge clk);
      chk("to_err", {30'h0, busy, err}, 32'h1);
      chk_regs("to");

      // argument on the timeout cycle wins
      send_byte(8'h61, e);
      repeat (TO - 1) @(negedge clk);
      send_byte(8'h5A, e);
      m_count = 8'h5A;
      chk("to_edge_err", {31'h0, e}, 32'h0);
      chk_regs("to_edge");

      // held response, then overrun while held
      send_byte(8'h62, e);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i % 5 == 4) chk("hold_stable", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, m_count});
      end
      send_byte(8'h63, e);
      chk("ovr_resp_err", {31'h0, e}, 32'h1);
      chk("ovr_resp_state", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, m_count});
      chk_regs("ovr_resp");
      // overrun coinciding with the transfer still returns to IDLE
      tx_ready = 1'b1;
      send_byte(8'h61, e);
      tx_ready = 1'b0;
      chk("ovr_xfer_err", {31'h0, e}, 32'h1);
      chk("ovr_xfer_idle", {30'h0, busy, tx_valid}, 32'h0);

      // overrun during MEM
      send_byte(8'hD0, e);
      send_byte(8'h62, e);
      chk("ovr_mem_err", {31'h0, e}, 32'h1);
      chk("ovr_mem_req", {30'h0, mem_req, mem_we}, 32'h3);
      mem_ack = 1'b1; @(negedge clk); mem_ack = 1'b0;
      chk("ovr_mem_ack", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, 8'hAA});
      accept("ovr_mem");

      // randomized traffic against the model
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 4))
            0: begin
               v = 8'($urandom_range(0, 255));
               do_write($urandom_range(0, 4), v, $urandom_range(0, TO - 2));
            end
            1: do_read($urandom_range(0, 4), $urandom_range(0, 3));
            2: do_mem(1'($urandom_range(0, 1)), $urandom_range(0, 6));
            3: do_bad();
            default: do_write($urandom_range(0, 4), 8'($urandom), 0);
         endcase
      end

      // asynchronous reset mid-ARG clears everything at once
      send_byte(8'h64, e);
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) m_addr[i] = 8'h00;
      m_count = 8'h00;
      chk("arst_state", {27'h0, busy, tx_valid, mem_req, mem_we, err}, 32'h0);
      chk_regs("arst");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      do_read(2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog");
   end
endmodule
